network_udiv_14ns_5ns_14_seq: RTL and testbench
===============================================

Name: network_udiv_14ns_5ns_14_seq

Overview:
- Sequential unsigned radix-2 restoring divider; arithmetic inverse of the network's 14-bit-product multipliers.
- Used for de-quantisation and rescaling: recovers a feature value from a 14-bit scaled product and a 5-bit scale.
- One quotient bit per enabled cycle; valid/ready handshake on both sides; ce-gated like the other network arithmetic cores.

Parameters:
- ID, 1, instance identifier; no functional effect.
- din0_WIDTH, 14, dividend width and quotient width.
- din1_WIDTH, 5, divisor width and remainder width.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; when low, all state holds and no handshake completes.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept an operand pair.
- din0  in  din0_WIDTH  unsigned dividend.
- din1  in  din1_WIDTH  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quot  out  din0_WIDTH  unsigned quotient.
- rem  out  din1_WIDTH  unsigned remainder.
- div0  out  1  divisor was zero.

Behaviour:
- Reset (ap_rst=1 at an edge, regardless of ce or state):
  - state=IDLE; in_ready=1; out_valid=0; quot=0; rem=0; div0=0; counter=0.
  - An in-flight division is discarded.
- FSM states: IDLE, BUSY, DONE. Nothing advances on an edge where ce=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&ce: latch din0 into the shift register and din1 into the divisor register; clear the partial remainder.
  - If din1 != 0: counter=din0_WIDTH, go to BUSY.
  - If din1 == 0: quot=all ones, rem=din0[din1_WIDTH-1:0], div0=1, go directly to DONE.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each ce edge performs one restoring step:
    - t = {partial_rem, dividend_msb}, computed din1_WIDTH+1 bits wide;
    - if t >= divisor, partial_rem = t - divisor and the quotient bit is 1;
    - otherwise partial_rem = t[din1_WIDTH-1:0] and the quotient bit is 0;
    - the quotient bit shifts into the LSB of the shift register.
  - Counter decrements each step. On the step where counter==1, go to DONE.
- DONE:
  - out_valid=1; quot, rem and div0 stable; in_ready=0.
  - On out_ready&ce: go to IDLE and drop out_valid.
  - No same-cycle accept of a new operand pair.
- Latency and throughput:
  - out_valid rises din0_WIDTH enabled edges after the accepting edge (14 by default); 1 edge for divide-by-zero.
  - Throughput is one result per din0_WIDTH+2 enabled cycles with out_ready held high.
- Invariants:
  - For a nonzero divisor, quot*din1 + rem == din0 and rem < din1.
  - Widths never overflow, because partial_rem < divisor <= 2^din1_WIDTH-1.
- Outputs are registered; no combinational path from inputs to outputs.
- in_valid during BUSY or DONE is ignored; the source holds its operands until in_ready.

Decomposition:
- Shared package network_arith_pkg holds:
  - width constants DIV_DIVIDEND_W=14 and DIV_DIVISOR_W=5;
  - state enum {IDLE, BUSY, DONE};
  - the all-ones divide-by-zero quotient constant.
- One combinational sub-module, network_udiv_step: inputs partial_rem, incoming bit and divisor; outputs next partial_rem and the quotient bit. This lets the bench check a single step in isolation.

Test Plan:
- din0=200, din1=7, out_ready=1, ce=1 -> out_valid after exactly 14 edges; quot=28, rem=4, div0=0; in_ready low from acceptance until return to IDLE.
- din0=16383, din1=31 -> quot=528, rem=15. Then din0=10235, din1=5 (inverse of 2047*5) -> quot=2047, rem=0.
- din0=1234, din1=0 -> out_valid one edge after acceptance; quot=16383, rem=18 (1234 mod 32), div0=1.
- Backpressure and stall:
  - Hold out_ready=0 for 10 cycles after 100/3 completes -> out_valid stays 1 with quot=33, rem=1 stable; completes on the first out_ready&ce edge.
  - Drop ce for 5 cycles mid-BUSY -> latency extends by exactly 5 cycles; result unchanged.
- Assert ap_rst for one edge at step 7 of 9999/9 -> next edge state IDLE, in_ready=1, out_valid=0, all outputs 0; a following 9999/9 yields quot=1111, rem=0.
- 2000 random operand pairs, including din0=0, din1=1 and din1=31, with random out_ready and ce -> every result satisfies quot*din1+rem==din0 and rem<din1 (div0 cases checked against their rule).

Source files
------------

// File: rtl/network_arith_pkg.sv
// Shared definitions for the network arithmetic cores.
//   DIV_DIVIDEND_W / DIV_DIVISOR_W : default divider operand widths
//   div_state_e                    : sequential divider FSM states
//   DIV0_QUOT                      : quotient reported on divide-by-zero (all ones,
//                                    truncated to the instance's dividend width)
package network_arith_pkg;

    localparam int unsigned DIV_DIVIDEND_W = 14;
    localparam int unsigned DIV_DIVISOR_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

    // Wide all-ones constant; callers truncate to their own dividend width.
    localparam logic [31:0] DIV0_QUOT = '1;

endpackage

// File: rtl/network_udiv_step.sv
// One restoring-division step.
//   partial_rem : current partial remainder (always < divisor)
//   in_bit      : next dividend bit, MSB first
//   divisor     : divisor (non-zero while stepping)
//   rem_next    : partial remainder after this step
//   qbit        : quotient bit produced by this step
module network_udiv_step #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] partial_rem,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         qbit
);

    logic [W:0]   t;
    logic [W-1:0] diff_lo;

    always_comb begin
        t       = {partial_rem, in_bit};
        qbit    = (t >= {1'b0, divisor});
        // The true difference is < divisor < 2^W, so the low W bits are exact.
        diff_lo = t[W-1:0] - divisor;
        rem_next = qbit ? diff_lo : t[W-1:0];
    end

endmodule

// File: rtl/network_udiv_14ns_5ns_14_seq.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per enabled cycle.
//   ap_clk, ap_rst      : clock, synchronous active-high reset
//   ce                  : clock enable; all state holds while low
//   in_valid / in_ready : operand handshake (din0 dividend, din1 divisor)
//   out_valid/out_ready : result handshake (quot, rem, div0)
// Divide-by-zero returns quot = all ones, rem = low divisor-width bits of din0, div0 = 1.
module network_udiv_14ns_5ns_14_seq
    import network_arith_pkg::*;
#(
    parameter int unsigned ID         = 1,
    parameter int unsigned din0_WIDTH = DIV_DIVIDEND_W,
    parameter int unsigned din1_WIDTH = DIV_DIVISOR_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div0
);

    localparam int unsigned CntW = $clog2(din0_WIDTH + 1);

    div_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
    logic [din0_WIDTH-1:0] shreg_q, shreg_d;
    logic [din1_WIDTH-1:0] prem_q, prem_d;
    logic [din1_WIDTH-1:0] divisor_q, divisor_d;
    logic [din0_WIDTH-1:0] quot_q, quot_d;
    logic [din1_WIDTH-1:0] rem_q, rem_d;
    logic                  div0_q, div0_d;

    logic [din1_WIDTH-1:0] step_rem;
    logic                  step_qbit;

    network_udiv_step #(
        .W (din1_WIDTH)
    ) u_step (
        .partial_rem (prem_q),
        .in_bit      (shreg_q[din0_WIDTH-1]),
        .divisor     (divisor_q),
        .rem_next    (step_rem),
        .qbit        (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        prem_d    = prem_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        div0_d    = div0_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = din0;
                    divisor_d = din1;
                    prem_d    = '0;
                    if (din1 != '0) begin
                        cnt_d   = CntW'(din0_WIDTH);
                        div0_d  = 1'b0;
                        state_d = BUSY;
                    end else begin
                        quot_d  = din0_WIDTH'(DIV0_QUOT);
                        rem_d   = din0[din1_WIDTH-1:0];
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                shreg_d = {shreg_q[din0_WIDTH-2:0], step_qbit};
                prem_d  = step_rem;
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    quot_d  = {shreg_q[din0_WIDTH-2:0], step_qbit};
                    rem_d   = step_rem;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            prem_q    <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            div0_q    <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            prem_q    <= prem_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            div0_q    <= div0_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_network_udiv_14ns_5ns_14_seq.sv
// Self-checking bench for network_udiv_14ns_5ns_14_seq: directed cases followed by
// randomized operands with random ce/out_ready; results checked through a scoreboard.
module tb_network_udiv_14ns_5ns_14_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] din0;
    logic [4:0]  din1;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] quot;
    logic [4:0]  rem;
    logic        div0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int q;
        int r;
        int z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    network_udiv_14ns_5ns_14_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div0      (div0)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = 16383;
            e.r = a % 32;
            e.z = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 0;
        end
        return e;
    endfunction

    // Handshakes complete on the next rising edge; sample them mid-cycle.
    always @(negedge ap_clk) begin
        if (ap_rst === 1'b0 && ce === 1'b1) begin
            if (out_valid && out_ready) begin
                check("sb_has_entry", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("sb_quot", 32'(quot), mon_e.q);
                    check("sb_rem", 32'(rem), mon_e.r);
                    check("sb_div0", 32'(div0), mon_e.z);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(int'(din0), int'(din1)));
            end
        end
    end

    task automatic rand_ctl();
        ce        = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present an operand pair and return 1 ns after the accepting edge.
    task automatic send(input int a, input int b, input bit rnd);
        bit acc;
        logic [31:0] av;
        logic [31:0] bv;
        acc = 1'b0;
        av  = a;
        bv  = b;
        din0     = av[13:0];
        din1     = bv[4:0];
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !acc; i++) begin
            if (rnd) rand_ctl();
            acc = (in_ready === 1'b1) && ce;
            @(posedge ap_clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", 32'(acc), 1);
    endtask

    // Count edges until out_valid is seen (0 if already high).
    task automatic wait_out(output int edges, output bit saw_ready);
        edges     = 0;
        saw_ready = 1'b0;
        while (out_valid !== 1'b1 && edges < 300) begin
            @(posedge ap_clk);
            #1;
            edges++;
            if (in_ready !== 1'b0) saw_ready = 1'b1;
        end
    endtask

    initial begin
        int lat;
        int lat2;
        bit sr;
        bit ok;
        int a;
        int b;

        ap_rst    = 1'b1;
        ce        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_quot", 32'(quot), 0);
        check("rst_rem", 32'(rem), 0);
        check("rst_div0", 32'(div0), 0);

        ce        = 1'b1;
        out_ready = 1'b1;

        // 200 / 7
        send(200, 7, 1'b0);
        check("t1_busy_ready", 32'(in_ready), 0);
        wait_out(lat, sr);
        check("t1_latency", lat, 14);
        check("t1_ready_low", 32'(sr), 0);
        check("t1_quot", 32'(quot), 28);
        check("t1_rem", 32'(rem), 4);
        check("t1_div0", 32'(div0), 0);
        @(posedge ap_clk);
        #1;
        check("t1_idle_ready", 32'(in_ready), 1);
        check("t1_idle_valid", 32'(out_valid), 0);

        // Full-scale and exact-inverse cases
        send(16383, 31, 1'b0);
        wait_out(lat, sr);
        check("t2a_quot", 32'(quot), 528);
        check("t2a_rem", 32'(rem), 15);
        send(10235, 5, 1'b0);
        wait_out(lat, sr);
        check("t2b_latency", lat, 14);
        check("t2b_quot", 32'(quot), 2047);
        check("t2b_rem", 32'(rem), 0);

        // Divide by zero: DONE straight from the accepting edge
        send(1234, 0, 1'b0);
        wait_out(lat, sr);
        check("t3_latency", lat, 0);
        check("t3_quot", 32'(quot), 16383);
        check("t3_rem", 32'(rem), 18);
        check("t3_div0", 32'(div0), 1);

        // Output backpressure
        send(100, 3, 1'b0);
        out_ready = 1'b0;
        wait_out(lat, sr);
        check("t4_latency", lat, 14);
        ok = 1'b1;
        repeat (10) begin
            @(posedge ap_clk);
            #1;
            if (!(out_valid === 1'b1 && quot === 14'd33 && rem === 5'd1)) ok = 1'b0;
        end
        check("t4_hold", 32'(ok), 1);
        check("t4_quot", 32'(quot), 33);
        check("t4_rem", 32'(rem), 1);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("t4_release", 32'(out_valid), 0);

        // Clock-enable stall mid-BUSY
        send(200, 7, 1'b0);
        lat = 0;
        repeat (5) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        ce = 1'b0;
        repeat (5) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        ce = 1'b1;
        wait_out(lat2, sr);
        check("t5_latency", lat + lat2, 19);
        check("t5_quot", 32'(quot), 28);
        check("t5_rem", 32'(rem), 4);

        // Reset in the middle of a division
        send(9999, 9, 1'b0);
        repeat (7) begin
            @(posedge ap_clk);
            #1;
        end
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        sb.delete();
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_quot", 32'(quot), 0);
        check("t6_rem", 32'(rem), 0);
        check("t6_div0", 32'(div0), 0);
        send(9999, 9, 1'b0);
        wait_out(lat, sr);
        check("t6_latency", lat, 14);
        check("t6_quot_after", 32'(quot), 1111);
        check("t6_rem_after", 32'(rem), 0);

        // Random operands with random ce / out_ready
        for (int i = 0; i < 2000; i++) begin
            a = $urandom_range(0, 16383);
            b = $urandom_range(0, 31);
            if (i == 0) begin
                a = 0;
                b = 1;
            end else if (i == 1) begin
                b = 31;
            end else if (i == 2) begin
                a = 16383;
                b = 1;
            end else if (i % 50 == 3) begin
                b = 0;
            end
            send(a, b, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                rand_ctl();
                @(posedge ap_clk);
                #1;
            end
        end

        ce        = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge ap_clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
